// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: frame-boundary snapshot, leading-zero
// blanking, per-digit dp/enable, PWM brightness with a dark guard cycle per slot.
module sevenseg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DIM_BITS   = 3,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                      clk_7seg,
  input  logic                      Rst,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      blank_lz,
  input  logic [DIM_BITS-1:0]       brightness,
  input  logic                      freeze,
  output logic [NUM_DIGITS-1:0]     an_out,
  output logic [6:0]                sev_out,
  output logic                      dp_out,
  output logic                      frame_done
);

  localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W    = 4 * NUM_DIGITS;
  localparam logic [DIM_BITS-1:0] SLOT_MAX = '1;
  localparam logic [IDX_W-1:0]    DIG_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIM_BITS-1:0]   slot_q, slot_d;
  logic [IDX_W-1:0]      dig_q, dig_d;
  logic [DIM_BITS-1:0]   bright_q, bright_d;
  logic [VAL_W-1:0]      snap_val_q, snap_val_d;
  logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0] snap_en_q, snap_en_d;
  logic                  snap_blz_q, snap_blz_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            sev_q, sev_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;

  logic                  boundary_c;
  logic                  blank_c;
  logic                  lit_c;
  logic [3:0]            nib_c;
  logic [NUM_DIGITS-1:0] upper_zero_c;
  logic [NUM_DIGITS-1:0] an_hi_c;
  logic [6:0]            sev_hi_c;
  logic                  dp_hi_c;

  // Active-low abcdefg pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b0000001;
      4'h1:    pat = 7'b1001111;
      4'h2:    pat = 7'b0010010;
      4'h3:    pat = 7'b0000110;
      4'h4:    pat = 7'b1001100;
      4'h5:    pat = 7'b0100100;
      4'h6:    pat = 7'b0100000;
      4'h7:    pat = 7'b0001111;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0000100;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b1100000;
      4'hC:    pat = 7'b0110001;
      4'hD:    pat = 7'b1000010;
      4'hE:    pat = 7'b0110000;
      default: pat = 7'b0111000;
    endcase
    return pat;
  endfunction

  // upper_zero_c[d]: nibbles d..NUM_DIGITS-1 of the snapshot are all zero.
  always_comb begin
    logic acc;
    acc          = 1'b1;
    upper_zero_c = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc             = acc & (snap_val_q[4*i +: 4] == 4'h0);
      upper_zero_c[i] = acc;
    end
  end

  // Scan counters, snapshot capture and per-slot brightness latch.
  always_comb begin
    slot_d     = slot_q + DIM_BITS'(1);
    dig_d      = dig_q;
    bright_d   = bright_q;
    snap_val_d = snap_val_q;
    snap_dp_d  = snap_dp_q;
    snap_en_d  = snap_en_q;
    snap_blz_d = snap_blz_q;
    boundary_c = (dig_q == DIG_LAST) && (slot_q == SLOT_MAX);

    if (slot_q == SLOT_MAX) begin
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + IDX_W'(1);
    end
    if (slot_q == '0) begin
      bright_d = brightness;
    end
    if (boundary_c && !freeze) begin
      snap_val_d = value;
      snap_dp_d  = dp_in;
      snap_en_d  = digit_en;
      snap_blz_d = blank_lz;
    end
  end

  // Lit decision and output drive, formed high-true then polarity-adjusted.
  always_comb begin
    nib_c    = snap_val_q[{dig_q, 2'b00} +: 4];
    blank_c  = snap_blz_q && (dig_q != '0) && upper_zero_c[dig_q];
    lit_c    = snap_en_q[dig_q] && !blank_c && (slot_q != '0) && (slot_q <= bright_q);
    an_hi_c  = '0;
    sev_hi_c = '0;
    dp_hi_c  = 1'b0;
    if (lit_c) begin
      an_hi_c[dig_q] = 1'b1;
      sev_hi_c       = ~seg_decode(nib_c);
      dp_hi_c        = snap_dp_q[dig_q];
    end
    an_d  = an_hi_c ^ {NUM_DIGITS{ACTIVE_LOW}};
    sev_d = sev_hi_c ^ {7{ACTIVE_LOW}};
    dp_d  = dp_hi_c ^ ACTIVE_LOW;
    fd_d  = boundary_c;
  end

  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      slot_q     <= '0;
      dig_q      <= '0;
      bright_q   <= '0;
      snap_val_q <= '0;
      snap_dp_q  <= '0;
      snap_en_q  <= '1;
      snap_blz_q <= 1'b0;
      an_q       <= {NUM_DIGITS{ACTIVE_LOW}};
      sev_q      <= {7{ACTIVE_LOW}};
      dp_q       <= ACTIVE_LOW;
      fd_q       <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      dig_q      <= dig_d;
      bright_q   <= bright_d;
      snap_val_q <= snap_val_d;
      snap_dp_q  <= snap_dp_d;
      snap_en_q  <= snap_en_d;
      snap_blz_q <= snap_blz_d;
      an_q       <= an_d;
      sev_q      <= sev_d;
      dp_q       <= dp_d;
      fd_q       <= fd_d;
    end
  end

  assign an_out     = an_q;
  assign sev_out    = sev_q;
  assign dp_out     = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl at default parameters: frame-position reference model
// plus directed scenario checks and a randomized soak.
module tb_sevenseg_scan_ctrl;

  localparam int FRAME = 64;
  localparam int SLOT  = 8;

  logic        clk_7seg = 1'b0;
  logic        Rst;
  logic [31:0] value;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic        blank_lz;
  logic [2:0]  brightness;
  logic        freeze;
  logic [7:0]  an_out;
  logic [6:0]  sev_out;
  logic        dp_out;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: t is the frame-position index of the next counter state.
  int          t = 0;
  logic [31:0] m_val;
  logic [7:0]  m_dp, m_en;
  logic        m_blz;
  int          mb;
  // Expected outputs for the state just clocked out, and that state's context.
  logic [7:0]  e_an;
  logic [6:0]  e_sev;
  logic        e_dp, e_fd, o_lit;
  int          o_dig, o_slot;
  logic [31:0] o_val;
  logic [7:0]  o_en;
  logic        o_blz;

  always #5 clk_7seg = ~clk_7seg;

  sevenseg_scan_ctrl #(.NUM_DIGITS(8), .DIM_BITS(3), .ACTIVE_LOW(1'b1)) dut (
    .clk_7seg(clk_7seg), .Rst(Rst), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .blank_lz(blank_lz), .brightness(brightness), .freeze(freeze), .an_out(an_out),
    .sev_out(sev_out), .dp_out(dp_out), .frame_done(frame_done)
  );

  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    logic [6:0] tab [16];
    tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
            7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return tab[n];
  endfunction

  // Advance one clock, update the model from the inputs sampled at that edge.
  task automatic tick();
    logic [3:0] nib;
    logic       blanked;
    @(posedge clk_7seg);
    if (Rst) begin
      e_an = 8'hFF; e_sev = 7'h7F; e_dp = 1'b1; e_fd = 1'b0; o_lit = 1'b0;
      o_dig = -1; o_slot = -1;
      t = 0; m_val = '0; m_dp = '0; m_en = 8'hFF; m_blz = 1'b0; mb = 0;
    end else begin
      o_dig   = (t % FRAME) / SLOT;
      o_slot  = t % SLOT;
      o_val   = m_val; o_en = m_en; o_blz = m_blz;
      nib     = 4'(m_val >> (4 * o_dig));
      blanked = m_blz && (o_dig > 0) && ((m_val >> (4 * o_dig)) == 32'h0);
      o_lit   = m_en[o_dig] && !blanked && (o_slot >= 1) && (o_slot <= mb);
      e_an    = o_lit ? ~(8'(1) << o_dig) : 8'hFF;
      e_sev   = o_lit ? exp_seg(nib) : 7'h7F;
      e_dp    = !(o_lit && m_dp[o_dig]);
      e_fd    = (t % FRAME) == FRAME - 1;
      if (e_fd && !freeze) begin
        m_val = value; m_dp = dp_in; m_en = digit_en; m_blz = blank_lz;
      end
      if (o_slot == 0) mb = int'(brightness);
      t++;
    end
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; value = $urandom; dp_in = 8'($urandom); digit_en = 8'($urandom);
    blank_lz = 1'($urandom); brightness = 3'($urandom); freeze = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({an_out, sev_out, dp_out, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d an=%h sev=%b dp=%b fd=%b need FF/1111111/1/0",
                 i, an_out, sev_out, dp_out, frame_done);
      end
    end
    Rst = 1'b0;
    tick();
    n_cmp++;
    if ({an_out, sev_out, dp_out, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_release an=%h sev=%b dp=%b fd=%b need FF/1111111/1/0",
               an_out, sev_out, dp_out, frame_done);
    end
  endtask

  task automatic test_scan();
    int         last_fd = -1;
    int         hits = 0;
    logic [6:0] es;
    value = 32'h76543210; brightness = 3'd7; digit_en = 8'hFF; dp_in = 8'h00;
    blank_lz = 1'b0; freeze = 1'b0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick();
      n_cmp++;
      if ({an_out, sev_out, dp_out, frame_done} !== {e_an, e_sev, e_dp, e_fd}) begin
        n_err++;
        $display("FAIL scan_model t=%0d got %h/%b/%b/%b need %h/%b/%b/%b", t - 1,
                 an_out, sev_out, dp_out, frame_done, e_an, e_sev, e_dp, e_fd);
      end
      if (frame_done) begin
        if (last_fd >= 0) begin
          n_cmp++;
          if (c - last_fd != FRAME) begin
            n_err++;
            $display("FAIL scan_fd_period got %0d need %0d", c - last_fd, FRAME);
          end
        end
        last_fd = c;
      end
      if (o_slot == 0) begin
        n_cmp++;
        if (an_out !== 8'hFF) begin
          n_err++;
          $display("FAIL scan_guard dig=%0d an=%h need FF", o_dig, an_out);
        end
      end else if (o_val == 32'h76543210 && (o_dig == 0 || o_dig == 1 || o_dig == 7)) begin
        es = (o_dig == 0) ? 7'b0000001 : (o_dig == 1) ? 7'b1001111 : 7'b0001111;
        hits++;
        n_cmp++;
        if (sev_out !== es || an_out !== ~(8'(1) << o_dig)) begin
          n_err++;
          $display("FAIL scan_digit dig=%0d an=%h sev=%b need sev=%b", o_dig, an_out, sev_out, es);
        end
      end
    end
    n_cmp++;
    if (hits == 0 || last_fd < 0) begin
      n_err++;
      $display("FAIL scan_coverage hits=%0d last_fd=%0d need >0", hits, last_fd);
    end
  endtask

  task automatic test_brightness();
    int cnt [8];
    brightness = 3'd0;
    for (int c = 0; c < 9; c++) tick();
    for (int c = 0; c < FRAME; c++) begin
      tick();
      n_cmp++;
      if (an_out !== 8'hFF) begin
        n_err++;
        $display("FAIL bright0 an=%h need FF", an_out);
      end
    end
    brightness = 3'd3;
    for (int c = 0; c < 9; c++) tick();
    for (int d = 0; d < 8; d++) cnt[d] = 0;
    for (int c = 0; c < FRAME; c++) begin
      tick();
      for (int d = 0; d < 8; d++) if (an_out[d] === 1'b0) cnt[d]++;
    end
    for (int d = 0; d < 8; d++) begin
      n_cmp++;
      if (cnt[d] != 3) begin
        n_err++;
        $display("FAIL bright3 dig=%0d lit=%0d need 3", d, cnt[d]);
      end
    end
  endtask

  task automatic test_blank_dp();
    brightness = 3'd7; value = 32'h00000A05; blank_lz = 1'b1; dp_in = 8'h09;
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick();
      if (o_val == 32'h00000A05 && o_blz) begin
        n_cmp++;
        if (an_out[7:3] !== 5'h1F) begin
          n_err++;
          $display("FAIL blank_hi dig=%0d an=%h need [7:3]=1F", o_dig, an_out);
        end
        if (o_slot >= 1 && o_dig == 2) begin
          n_cmp++;
          if (an_out !== 8'hFB || sev_out !== 7'b0001000) begin
            n_err++;
            $display("FAIL blank_d2 an=%h sev=%b need FB/0001000", an_out, sev_out);
          end
        end
        if (o_slot >= 1 && o_dig == 1) begin
          n_cmp++;
          if (an_out !== 8'hFD || sev_out !== 7'b0000001 || dp_out !== 1'b1) begin
            n_err++;
            $display("FAIL blank_d1 an=%h sev=%b dp=%b need FD/0000001/1", an_out, sev_out, dp_out);
          end
        end
        if (o_slot >= 1 && o_dig == 0) begin
          n_cmp++;
          if (an_out !== 8'hFE || sev_out !== 7'b0100100 || dp_out !== 1'b0) begin
            n_err++;
            $display("FAIL blank_d0 an=%h sev=%b dp=%b need FE/0100100/0", an_out, sev_out, dp_out);
          end
        end
      end
    end
    value = 32'h0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick();
      if (o_val == 32'h0 && o_blz) begin
        n_cmp++;
        if (an_out[7:1] !== 7'h7F) begin
          n_err++;
          $display("FAIL blank_zero_hi dig=%0d an=%h need [7:1]=7F", o_dig, an_out);
        end
        if (o_slot >= 1 && o_dig == 0) begin
          n_cmp++;
          if (an_out !== 8'hFE || sev_out !== 7'b0000001) begin
            n_err++;
            $display("FAIL blank_zero_d0 an=%h sev=%b need FE/0000001", an_out, sev_out);
          end
        end
      end
    end
  endtask

  task automatic test_tearfree_freeze();
    bit found = 0;
    blank_lz = 1'b0; dp_in = 8'h00; digit_en = 8'hFF; brightness = 3'd7;
    freeze = 1'b0; value = 32'h11111111;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (m_val == 32'h11111111 && (t % FRAME) == 20) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL tear_align found=%0d need 1", found);
    end
    value = 32'h22222222;
    found = 0;
    for (int c = 0; c < 80 && !found; c++) begin
      tick();
      if (o_lit) begin
        n_cmp++;
        if (sev_out !== 7'b1001111) begin
          n_err++;
          $display("FAIL tear_old dig=%0d sev=%b need 1001111", o_dig, sev_out);
        end
      end
      if (e_fd) begin
        found = 1;
        n_cmp++;
        if (frame_done !== 1'b1) begin
          n_err++;
          $display("FAIL tear_fd got %b need 1", frame_done);
        end
      end
    end
    freeze = 1'b1; value = 32'h33333333;
    for (int c = 0; c < 4 * FRAME; c++) begin
      if (c == 3 * FRAME) freeze = 1'b0;
      tick();
      if (o_lit) begin
        n_cmp++;
        if (sev_out !== 7'b0010010) begin
          n_err++;
          $display("FAIL freeze_hold c=%0d sev=%b need 0010010", c, sev_out);
        end
      end
    end
    for (int c = 0; c < FRAME; c++) begin
      tick();
      if (o_lit) begin
        n_cmp++;
        if (sev_out !== 7'b0000110) begin
          n_err++;
          $display("FAIL freeze_release c=%0d sev=%b need 0000110", c, sev_out);
        end
      end
    end
  endtask

  task automatic test_mask_rst();
    int last_fd = -1;
    bit found = 0;
    digit_en = 8'h0F; value = $urandom | 32'h1; blank_lz = 1'b0; brightness = 3'd7;
    for (int c = 0; c < 3 * FRAME; c++) begin
      tick();
      if (o_en == 8'h0F) begin
        n_cmp++;
        if (an_out[7:4] !== 4'hF) begin
          n_err++;
          $display("FAIL mask_hi dig=%0d an=%h need [7:4]=F", o_dig, an_out);
        end
      end
      if (frame_done) begin
        if (last_fd >= 0) begin
          n_cmp++;
          if (c - last_fd != FRAME) begin
            n_err++;
            $display("FAIL mask_fd_period got %0d need %0d", c - last_fd, FRAME);
          end
        end
        last_fd = c;
      end
    end
    for (int c = 0; c < 100 && (t % FRAME) != 37; c++) tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    n_cmp++;
    if ({an_out, sev_out, dp_out, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL midrst an=%h sev=%b dp=%b fd=%b need FF/1111111/1/0",
               an_out, sev_out, dp_out, frame_done);
    end
    for (int c = 0; c < 100 && !found; c++) begin
      tick();
      if (an_out !== 8'hFF) begin
        found = 1;
        n_cmp++;
        if (an_out !== 8'hFE || sev_out !== 7'b0000001 || c != 1) begin
          n_err++;
          $display("FAIL midrst_first an=%h sev=%b cyc=%0d need FE/0000001/1", an_out, sev_out, c);
        end
      end
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL midrst_nolit found=%0d need 1", found);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) value = $urandom >> (4 * $urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) dp_in = 8'($urandom);
      if ($urandom_range(0, 15) == 0) digit_en = 8'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 31) == 0) brightness = 3'($urandom);
      if ($urandom_range(0, 63) == 0) freeze = ~freeze;
      Rst = ($urandom_range(0, 299) == 0);
      tick();
      n_cmp++;
      if ({an_out, sev_out, dp_out, frame_done} !== {e_an, e_sev, e_dp, e_fd}) begin
        n_err++;
        $display("FAIL random c=%0d got %h/%b/%b/%b need %h/%b/%b/%b", c,
                 an_out, sev_out, dp_out, frame_done, e_an, e_sev, e_dp, e_fd);
      end
    end
    Rst = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; value = '0; dp_in = '0; digit_en = 8'hFF; blank_lz = 1'b0;
    brightness = 3'd7; freeze = 1'b0;
    test_reset();
    test_scan();
    test_brightness();
    test_blank_dp();
    test_tearfree_freeze();
    test_mask_rst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
